data_mem_lsu: RTL
=================

// Module: data_mem_lsu
// PURPOSE
//  Load/store unit with a private synchronous word-organised data memory. It sits
//  upstream of the result-source writeback mux and supplies ReadData to it. Accepts
//  one load/store request at a time over a valid/ready handshake. Performs RV32
//  byte/half/word access with byte enables, little-endian lane select, sign/zero
//  extension, and misalignment/illegal-width detection.
// PARAMETERS
//  Data_Width  32  data and address port width; fixed at 32, other values unsupported
//  Addr_Width  12  byte-address bits decoded; memory depth = 2**(Addr_Width-2) words
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           synchronous active-high reset
//  ReqValid       in   1           request present on Address/WriteData/Funct3/MemWrite
//  ReqReady       out  1           unit idle; request accepted when ReqValid & ReqReady
//  MemWrite       in   1           1 = store, 0 = load
//  Funct3         in   3           000 B, 001 H, 010 W, 100 BU, 101 HU (load only)
//  Address        in   Data_Width  byte address; bits above Addr_Width-1 ignored
//  WriteData      in   Data_Width  store data; low byte/half used for SB/SH
//  RespValid      out  1           one-cycle pulse: response on ReadData/MisalignFault
//  ReadData       out  Data_Width  extended load data; 0 for stores and faults
//  MisalignFault  out  1           valid with RespValid; misaligned or illegal Funct3
// BEHAVIOUR
//  - States: IDLE -> ACCESS -> RESP -> IDLE. A faulting request goes IDLE -> RESP.
//  - IDLE: ReqReady=1. On handshake, register Address, WriteData, Funct3 and MemWrite.
//    Classify the request:
//    fault if H/HU with Address[0]=1, W with Address[1:0]!=0, Funct3 in {011,110,111},
//    or a store with Funct3 in {100,101}.
//    Fault -> RESP, memory untouched. Otherwise -> ACCESS.
//  - ACCESS: ReqReady=0. Word index = Address[Addr_Width-1:2].
//    Store: write lanes selected by Address[1:0] this cycle (SB 1 lane, SH 2, SW 4);
//    other lanes keep their value.
//    Load: read the word this cycle. Go to RESP.
//  - RESP: ReqReady=0, RespValid=1 for exactly one cycle, no backpressure. Go to IDLE.
//    New requests are accepted only in IDLE, so back-to-back issue is every 3 cycles.
//  - Latency: handshake in cycle N -> RespValid in N+2 (faults in N+1).
//  - Load extract (little-endian): B/BU take byte Address[1:0]; H/HU take half Address[1].
//    B/H sign-extend bit 7/15 to 32 bits; BU/HU zero-extend; W is returned unmodified.
//  - ReadData and MisalignFault are registered and held until the next response.
//    They are meaningful only while RespValid=1.
//  - Reset: state=IDLE, ReqReady=1 from the cycle after reset, RespValid=0,
//    ReadData=0, MisalignFault=0.
//    Memory contents are not reset.
//    rst has priority over everything: if rst=1 during ACCESS, a pending store is
//    NOT written. An in-flight response is dropped.
//  - Address wrap: addresses >= 2**Addr_Width alias modulo 2**Addr_Width.
//  - ReqValid while ReqReady=0 is ignored. The requester must hold the request
//    until the handshake.
// TESTING
//  1 SW 0xDEADBEEF @0x010, then LW @0x010 -> RespValid 2 cycles after each
//    handshake; ReadData=0xDEADBEEF, fault=0.
//  2 After test 1: SB 0x7F @0x013, then LB @0x013 -> 0x0000007F;
//    LW @0x010 -> 0x7FADBEEF; LBU @0x012 -> 0x000000AD; LB @0x012 -> 0xFFFFFFAD.
//  3 SH 0x8001 @0x022, then LH @0x022 -> 0xFFFF8001; LHU @0x022 -> 0x00008001;
//    LW @0x020 upper half = 0x8001.
//  4 LW @0x011, SH @0x023, LBU-store (MemWrite=1, Funct3=100), Funct3=011
//    -> each returns MisalignFault=1 one cycle after handshake with ReadData=0;
//    memory is unchanged (re-read word at 0x010 still 0x7FADBEEF).
//  5 SW 0x12345678 @0x1000 (aliases 0x000) -> LW @0x000 returns 0x12345678.
//    ReqValid held high during ACCESS/RESP -> no extra accept.
//  6 Assert rst during ACCESS of SW 0xAAAAAAAA @0x030 (word previously 0x11111111)
//    -> all outputs at reset values next cycle; LW @0x030 returns 0x11111111.

Source files
------------

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between a requester and the load/store unit.
// Requests use valid/ready; responses are a single-cycle pulse.
interface data_mem_lsu_if #(
    parameter int Data_Width = 32
) ();
    logic                  ReqValid;
    logic                  ReqReady;
    logic                  MemWrite;
    logic [2:0]            Funct3;
    logic [Data_Width-1:0] Address;
    logic [Data_Width-1:0] WriteData;
    logic                  RespValid;
    logic [Data_Width-1:0] ReadData;
    logic                  MisalignFault;

    modport master (
        output ReqValid, MemWrite, Funct3, Address, WriteData,
        input  ReqReady, RespValid, ReadData, MisalignFault
    );

    modport slave (
        input  ReqValid, MemWrite, Funct3, Address, WriteData,
        output ReqReady, RespValid, ReadData, MisalignFault
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit with private word-organised data memory.
// Byte/half/word access, lane select, extension and fault detection.
module data_mem_lsu #(
    parameter int Data_Width = 32,
    parameter int Addr_Width = 12
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_lsu_if.slave bus
);
    localparam int Depth = 2 ** (Addr_Width - 2);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_n;

    logic [Data_Width-1:0] mem [Depth];

    logic [Addr_Width-1:0] addr_q;
    logic [Data_Width-1:0] wdata_q;
    logic [2:0]            f3_q;
    logic                  we_q;
    logic [Data_Width-1:0] rdata_q;
    logic                  fault_q;

    logic                  ready;
    logic                  resp;
    logic                  req_fire;
    logic                  req_fault;
    logic [Data_Width-1:0] word;
    logic [Data_Width-1:0] load_val;
    logic [Data_Width-1:0] wr_data;
    logic [3:0]            be;
    logic [7:0]            lb;
    logic [15:0]           lh;
    logic                  unused_addr;

    assign unused_addr = ^bus.Address[Data_Width-1:Addr_Width];

    always_comb begin
        req_fault = 1'b0;
        unique case (bus.Funct3)
            3'b000, 3'b100: req_fault = 1'b0;
            3'b001, 3'b101: req_fault = bus.Address[0];
            3'b010:         req_fault = |bus.Address[1:0];
            default:        req_fault = 1'b1;
        endcase
        // Unsigned variants exist only for loads
        if (bus.MemWrite && bus.Funct3[2]) req_fault = 1'b1;
    end

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        resp    = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.ReqValid) state_n = req_fault ? RESP : ACCESS;
            end
            ACCESS: state_n = RESP;
            RESP: begin
                resp    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign req_fire = ready & bus.ReqValid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (req_fire) begin
                addr_q  <= bus.Address[Addr_Width-1:0];
                wdata_q <= bus.WriteData;
                f3_q    <= bus.Funct3;
                we_q    <= bus.MemWrite;
                if (req_fault) begin
                    rdata_q <= '0;
                    fault_q <= 1'b1;
                end
            end
            if (state == ACCESS) begin
                rdata_q <= we_q ? '0 : load_val;
                fault_q <= 1'b0;
            end
        end
    end

    assign word = mem[addr_q[Addr_Width-1:2]];

    always_comb begin
        lb = word[7:0];
        unique case (addr_q[1:0])
            2'd0: lb = word[7:0];
            2'd1: lb = word[15:8];
            2'd2: lb = word[23:16];
            2'd3: lb = word[31:24];
            default: lb = word[7:0];
        endcase
        lh = addr_q[1] ? word[31:16] : word[15:0];
        unique case (f3_q)
            3'b000:  load_val = {{(Data_Width-8){lb[7]}}, lb};
            3'b001:  load_val = {{(Data_Width-16){lh[15]}}, lh};
            3'b100:  load_val = {{(Data_Width-8){1'b0}}, lb};
            3'b101:  load_val = {{(Data_Width-16){1'b0}}, lh};
            default: load_val = word;
        endcase
    end

    // Replicate store data across lanes so the enables alone pick the target
    always_comb begin
        be      = 4'b1111;
        wr_data = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                be      = 4'b0001 << addr_q[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[addr_q[Addr_Width-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign bus.ReqReady      = ready;
    assign bus.RespValid     = resp;
    assign bus.ReadData      = rdata_q;
    assign bus.MisalignFault = fault_q;
endmodule
